// File: rtl/video_scandbl.sv
// Scan doubler: stores each TV line in a ping-pong line buffer and replays it
// twice at double pixel rate, with VGA-rate hsync/vsync aligned to the colour.
module video_scandbl #(
  parameter int LINE_CLKS = 896,
  parameter int BUF_AW    = 9,
  parameter int HS_BEG    = 400,
  parameter int HS_LEN    = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_stb,
  input  logic [5:0] color_in,
  input  logic       hsync_start,
  input  logic       vsync_in,
  output logic [5:0] vga_color,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_line,
  output logic       ovf
);

  localparam int HSW = $clog2(HS_LEN + 1);
  localparam logic [BUF_AW:0] HC_MAX    = {(BUF_AW + 1){1'b1}};
  localparam logic [BUF_AW:0] HC_REPLAY = (BUF_AW + 1)'(LINE_CLKS / 2 - 1);
  localparam logic [BUF_AW:0] RA_HS     = (BUF_AW + 1)'(HS_BEG);
  localparam logic [HSW-1:0]  HS_RELOAD = HSW'(HS_LEN - 1);

  logic [5:0] mem0_q [2**BUF_AW];
  logic [5:0] mem1_q [2**BUF_AW];
  logic [5:0] rd0_q, rd1_q;

  logic              wb_q, wb_d;
  logic [BUF_AW:0]   wa_q, wa_d;
  logic [BUF_AW:0]   hc_q, hc_d;
  logic [BUF_AW:0]   rdLen_q, rdLen_d;
  logic [BUF_AW:0]   ra_q, ra_d;
  logic              primed_q, primed_d;
  logic              ovf_q, ovf_d;
  logic              line_q, line_d;
  logic              vsSmp_q, vsSmp_d;
  logic [HSW-1:0]    hsCnt_q, hsCnt_d;

  logic              rdSel_q, visP1_q, hsP1_q, vsP1_q;
  logic [5:0]        color_q;
  logic              hsOut_q, vsOut_q;

  logic              rs, wrBank, wrEn, raVis, hsRaw;
  logic [BUF_AW-1:0] wrAddr, rdAddr;

  // A pixel coincident with hsync_start belongs to the new line at address 0.
  assign rs     = hsync_start | (hc_q == HC_REPLAY);
  assign wrBank = wb_q ^ hsync_start;
  assign wrAddr = hsync_start ? '0 : wa_q[BUF_AW-1:0];
  assign wrEn   = pix_stb & ~rst & (hsync_start | ~wa_q[BUF_AW]);
  assign rdAddr = ra_q[BUF_AW-1:0];
  assign raVis  = ra_q < rdLen_q;
  assign hsRaw  = (ra_q == RA_HS) | (hsCnt_q != '0);

  always_ff @(posedge clk) begin
    if (wrEn && !wrBank) mem0_q[wrAddr] <= color_in;
    rd0_q <= mem0_q[rdAddr];
  end

  always_ff @(posedge clk) begin
    if (wrEn && wrBank) mem1_q[wrAddr] <= color_in;
    rd1_q <= mem1_q[rdAddr];
  end

  always_comb begin
    wb_d     = wb_q ^ hsync_start;
    wa_d     = wa_q;
    ovf_d    = ovf_q | (pix_stb & ~hsync_start & wa_q[BUF_AW]);
    rdLen_d  = rdLen_q;
    primed_d = primed_q | hsync_start;
    hc_d     = (hc_q == HC_MAX) ? hc_q : hc_q + 1'b1;
    ra_d     = ra_q[BUF_AW] ? ra_q : ra_q + 1'b1;
    line_d   = line_q;
    vsSmp_d  = vsSmp_q;
    hsCnt_d  = (hsCnt_q != '0) ? hsCnt_q - 1'b1 : hsCnt_q;

    if (hsync_start) begin
      wa_d    = {{BUF_AW{1'b0}}, pix_stb};
      // The first line after reset is partial, so it is never shown.
      rdLen_d = primed_q ? wa_q : '0;
      hc_d    = '0;
    end else if (pix_stb && !wa_q[BUF_AW]) begin
      wa_d = wa_q + 1'b1;
    end

    if (rs) begin
      ra_d    = '0;
      line_d  = ~hsync_start;
      vsSmp_d = vsync_in;
    end

    // The sync pulse runs its full width even if the next replay restarts ra.
    if (ra_q == RA_HS) hsCnt_d = HS_RELOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= 1'b0;
      wa_q     <= '0;
      hc_q     <= '0;
      rdLen_q  <= '0;
      ra_q     <= {1'b1, {BUF_AW{1'b0}}};
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
      line_q   <= 1'b0;
      vsSmp_q  <= 1'b0;
      hsCnt_q  <= '0;
      rdSel_q  <= 1'b0;
      visP1_q  <= 1'b0;
      hsP1_q   <= 1'b0;
      vsP1_q   <= 1'b0;
      color_q  <= '0;
      hsOut_q  <= 1'b0;
      vsOut_q  <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      wa_q     <= wa_d;
      hc_q     <= hc_d;
      rdLen_q  <= rdLen_d;
      ra_q     <= ra_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
      line_q   <= line_d;
      vsSmp_q  <= vsSmp_d;
      hsCnt_q  <= hsCnt_d;
      rdSel_q  <= ~wb_q;
      visP1_q  <= raVis;
      hsP1_q   <= hsRaw;
      vsP1_q   <= vsSmp_q;
      color_q  <= visP1_q ? (rdSel_q ? rd1_q : rd0_q) : 6'd0;
      hsOut_q  <= hsP1_q;
      vsOut_q  <= vsP1_q;
    end
  end

  assign vga_color = color_q;
  assign vga_hsync = hsOut_q;
  assign vga_vsync = vsOut_q;
  assign vga_line  = line_q;
  assign ovf       = ovf_q;

endmodule
